// File: rtl/mem_bist_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : mem_bist_seq                                                  |
// | Description: Memory BIST sequencer. Writes an address-derived pattern to   |
// |              N_WORDS addresses (BASE_ADDR + i*STRIDE, wrapping mod 2^27),  |
// |              reads them back and compares. Reports pass/fail, a saturating |
// |              error count and the first failing address.                    |
// |              Optional per-request watchdog: define MEM_BIST_TIMEOUT_EN.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module mem_bist_seq #(
  parameter int          N_WORDS        = 1024,
  parameter logic [26:0] BASE_ADDR      = 27'h0,
  parameter logic [26:0] STRIDE         = 27'h1,
  parameter logic [31:0] SEED           = 32'hA5A5_0000,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  // cpu_req_type, flattened
  output logic [26:0] cpu_req_addr,
  output logic [31:0] cpu_req_data,
  output logic        cpu_req_rw,
  output logic        cpu_req_valid,
  // cpu_result_type, flattened
  input  logic [31:0] cpu_res_data,
  input  logic        cpu_res_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [26:0] first_fail_addr,
  output logic        timeout,
  output logic        led_memory
);

  localparam logic [15:0] c_LAST_IDX = 16'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_WGAP  = 3'd2,
    S_READ  = 3'd3,
    S_RGAP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [26:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rw_q, rw_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] err_q, err_d;
  logic [26:0] ffa_q, ffa_d;
  logic        led_q, led_d;

`ifdef MEM_BIST_TIMEOUT_EN
  localparam logic [31:0] c_TIMEOUT = 32'(TIMEOUT_CYCLES);
  logic [31:0] wdog_q, wdog_d;
  logic        to_q, to_d;
`endif

  logic [26:0] w_addr_next;
  logic        w_last;
  logic        w_mismatch;

  // Expected word for an address: SEED ^ (a << 5) ^ a on 32 bits.
  function automatic logic [31:0] pat(input logic [26:0] a);
    return SEED ^ {a, 5'd0} ^ {5'd0, a};
  endfunction

  assign w_addr_next = addr_q + STRIDE;
  assign w_last      = (idx_q == c_LAST_IDX);
  assign w_mismatch  = (cpu_res_data != pat(addr_q));

  // Next-state and registered-output computation for the BIST sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    led_d   = led_q;
`ifdef MEM_BIST_TIMEOUT_EN
    to_d    = to_q;
    wdog_d  = wdog_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          idx_d   = 16'd0;
          addr_d  = BASE_ADDR;
          data_d  = pat(BASE_ADDR);
          rw_d    = 1'b1;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 16'd0;
          ffa_d   = 27'd0;
          led_d   = 1'b0;
`ifdef MEM_BIST_TIMEOUT_EN
          to_d    = 1'b0;
`endif
        end
      end

      S_WRITE: begin
        if (cpu_res_ready) begin
          state_d = S_WGAP;
          valid_d = 1'b0;
        end
      end

      S_WGAP: begin
        valid_d = 1'b1;
        if (w_last) begin
          // Switch to the read-back pass from the first address again.
          state_d = S_READ;
          idx_d   = 16'd0;
          addr_d  = BASE_ADDR;
          data_d  = 32'd0;
          rw_d    = 1'b0;
        end else begin
          state_d = S_WRITE;
          idx_d   = idx_q + 16'd1;
          addr_d  = w_addr_next;
          data_d  = pat(w_addr_next);
          rw_d    = 1'b1;
        end
      end

      S_READ: begin
        if (cpu_res_ready) begin
          state_d = S_RGAP;
          valid_d = 1'b0;
          if (w_mismatch) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
              ffa_d = addr_q;
            end
          end
        end
      end

      S_RGAP: begin
        if (w_last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 16'd0);
          led_d   = (err_q == 16'd0);
        end else begin
          state_d = S_READ;
          idx_d   = idx_q + 16'd1;
          addr_d  = w_addr_next;
          data_d  = 32'd0;
          rw_d    = 1'b0;
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

`ifdef MEM_BIST_TIMEOUT_EN
    // Watchdog restarts on each newly issued request and counts stalled cycles.
    if (valid_d && !valid_q) begin
      wdog_d = 32'd0;
    end else if (valid_q && !cpu_res_ready) begin
      wdog_d = wdog_q + 32'd1;
      if (wdog_d >= c_TIMEOUT) begin
        state_d = S_DONE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = 1'b0;
        led_d   = 1'b0;
        to_d    = 1'b1;
      end
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 16'd0;
      addr_q  <= 27'd0;
      data_q  <= 32'd0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 16'd0;
      ffa_q   <= 27'd0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      led_q   <= led_d;
    end
  end

`ifdef MEM_BIST_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wdog_q <= 32'd0;
      to_q   <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      to_q   <= to_d;
    end
  end

  assign timeout = to_q;
`else
  // No watchdog in this build: requests wait for ready indefinitely.
  // TIMEOUT_CYCLES has no effect here; it is referenced only so both builds
  // elaborate the same parameter set cleanly.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  assign cpu_req_addr    = addr_q;
  assign cpu_req_data    = data_q;
  assign cpu_req_rw      = rw_q;
  assign cpu_req_valid   = valid_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_fail_addr = ffa_q;
  assign led_memory      = led_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_mem_bist_seq                                               |
// | Description: Self-checking bench for mem_bist_seq. Three DUT instances     |
// |              (small, wrapping base, randomized) share one memory model.   |
// |              Timeout scenario is active when MEM_BIST_TIMEOUT_EN is set.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mem_bist_seq;

  localparam logic [31:0] SEED_A   = 32'hA5A5_0000;
  localparam logic [31:0] SEED_R   = 32'h1234_5678;
  localparam logic [26:0] BASE_R   = 27'h7FF_F800;
  localparam logic [26:0] STRIDE_R = 27'h100;

  // Per-instance configuration, used by the reference model.
  int          cfg_n      [3] = '{4, 4, 16};
  logic [26:0] cfg_base   [3] = '{27'h0, 27'h7FF_FFFE, BASE_R};
  logic [26:0] cfg_stride [3] = '{27'h1, 27'h1, STRIDE_R};
  logic [31:0] cfg_seed   [3] = '{SEED_A, SEED_A, SEED_R};

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [2:0]  rdy_v;

  logic [26:0] q_addr  [3];
  logic [31:0] q_data  [3];
  logic        q_rw    [3];
  logic        q_valid [3];
  logic        q_busy  [3];
  logic        q_done  [3];
  logic        q_pass  [3];
  logic [15:0] q_err   [3];
  logic [26:0] q_ffa   [3];
  logic        q_to    [3];
  logic        q_led   [3];

  // Memory model state
  int          sel;
  logic        m_valid, m_rw, m_ready;
  logic [26:0] m_addr;
  logic [31:0] m_data, m_rdata;
  int          m_cnt;
  int          lat_cfg;
  int          rnd_lat = 2;
  bit          rand_lat;
  bit          never_ready;
  logic [31:0] mem  [logic [26:0]];
  logic [31:0] cval [logic [26:0]];

  typedef struct {
    logic        rw;
    logic [26:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t        log_q[$];
  int          stab_bad;
  logic        pv_valid;
  logic [59:0] pv_fields;

  int n_checks = 0;
  int n_err    = 0;

  always #5 sys_clk = ~sys_clk;

  assign m_valid = q_valid[sel];
  assign m_rw    = q_rw[sel];
  assign m_addr  = q_addr[sel];
  assign m_data  = q_data[sel];
  assign rdy_v   = m_ready ? (3'b001 << sel) : 3'b000;

  mem_bist_seq #(.N_WORDS(4), .BASE_ADDR(27'h0), .STRIDE(27'h1), .SEED(SEED_A),
                 .TIMEOUT_CYCLES(16)) u_dut_a (
    .sys_clk(sys_clk), .rst(rst), .start(start_v[0]),
    .cpu_req_addr(q_addr[0]), .cpu_req_data(q_data[0]), .cpu_req_rw(q_rw[0]),
    .cpu_req_valid(q_valid[0]), .cpu_res_data(m_rdata), .cpu_res_ready(rdy_v[0]),
    .busy(q_busy[0]), .done(q_done[0]), .pass(q_pass[0]), .err_count(q_err[0]),
    .first_fail_addr(q_ffa[0]), .timeout(q_to[0]), .led_memory(q_led[0]));

  mem_bist_seq #(.N_WORDS(4), .BASE_ADDR(27'h7FF_FFFE), .STRIDE(27'h1), .SEED(SEED_A),
                 .TIMEOUT_CYCLES(4096)) u_dut_b (
    .sys_clk(sys_clk), .rst(rst), .start(start_v[1]),
    .cpu_req_addr(q_addr[1]), .cpu_req_data(q_data[1]), .cpu_req_rw(q_rw[1]),
    .cpu_req_valid(q_valid[1]), .cpu_res_data(m_rdata), .cpu_res_ready(rdy_v[1]),
    .busy(q_busy[1]), .done(q_done[1]), .pass(q_pass[1]), .err_count(q_err[1]),
    .first_fail_addr(q_ffa[1]), .timeout(q_to[1]), .led_memory(q_led[1]));

  mem_bist_seq #(.N_WORDS(16), .BASE_ADDR(BASE_R), .STRIDE(STRIDE_R), .SEED(SEED_R),
                 .TIMEOUT_CYCLES(4096)) u_dut_r (
    .sys_clk(sys_clk), .rst(rst), .start(start_v[2]),
    .cpu_req_addr(q_addr[2]), .cpu_req_data(q_data[2]), .cpu_req_rw(q_rw[2]),
    .cpu_req_valid(q_valid[2]), .cpu_res_data(m_rdata), .cpu_res_ready(rdy_v[2]),
    .busy(q_busy[2]), .done(q_done[2]), .pass(q_pass[2]), .err_count(q_err[2]),
    .first_fail_addr(q_ffa[2]), .timeout(q_to[2]), .led_memory(q_led[2]));

  function automatic logic [31:0] model_read(logic [26:0] a);
    if (cval.exists(a)) return cval[a];
    if (mem.exists(a))  return mem[a];
    return 32'hDEAD_BEEF;
  endfunction

  // Responder: one ready pulse per request after a configurable wait.
  always @(posedge sys_clk) begin
    if (rst) begin
      m_ready <= 1'b0;
      m_cnt   <= 0;
    end else if (m_ready) begin
      m_ready <= 1'b0;
      m_cnt   <= 0;
      rnd_lat <= int'($urandom_range(0, 4));
    end else if (m_valid && !never_ready) begin
      if (m_cnt >= (rand_lat ? rnd_lat : lat_cfg)) begin
        m_ready <= 1'b1;
        m_rdata <= m_rw ? 32'h0 : model_read(m_addr);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      m_cnt <= 0;
    end
  end

  // Reference values from plain arithmetic.
  function automatic logic [26:0] ref_addr(int s, int i);
    longint unsigned a;
    a = 64'(cfg_base[s]) + 64'(i) * 64'(cfg_stride[s]);
    return 27'(a % (64'd1 << 27));
  endfunction

  function automatic logic [31:0] ref_pat(int s, logic [26:0] a);
    return cfg_seed[s] ^ (32'(a) * 32'd32) ^ 32'(a);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and record any accepted transaction.
  task automatic tick();
    @(negedge sys_clk);
    if (!rst && m_valid && m_ready) begin
      log_q.push_back('{m_rw, m_addr, m_data});
      if (m_rw) mem[m_addr] = m_data;
    end
    if (!rst && m_valid && pv_valid && ({m_addr, m_data, m_rw} != pv_fields))
      stab_bad++;
    pv_valid  = m_valid && !rst;
    pv_fields = {m_addr, m_data, m_rw};
  endtask

  task automatic prep();
    mem.delete();
    log_q.delete();
    stab_bad = 0;
  endtask

  task automatic wait_done(int s, int budget);
    int k;
    k = 0;
    while (!q_done[s] && k < budget) begin
      tick();
      k++;
    end
    chk("done_reached", 64'(q_done[s]), 64'd1);
  endtask

  task automatic run_scn(int s, int budget);
    sel = s;
    prep();
    start_v[s] = 1'b1;
    tick();
    start_v = 3'b000;
    wait_done(s, budget);
  endtask

  // Whole write/read sequence against the reference address/pattern list.
  task automatic chk_seq(int s);
    int n, bad;
    n = cfg_n[s];
    bad = 0;
    chk("seq_len", 64'(log_q.size()), 64'(2 * n));
    if (log_q.size() == 2 * n) begin
      for (int i = 0; i < 2 * n; i++) begin
        logic [26:0] a;
        a = ref_addr(s, i % n);
        if (log_q[i].rw !== (i < n)) bad++;
        if (log_q[i].addr !== a) bad++;
        if (log_q[i].data !== ((i < n) ? ref_pat(s, a) : 32'h0)) bad++;
      end
    end
    chk("seq_fields", 64'(bad), 64'd0);
    chk("req_stable", 64'(stab_bad), 64'd0);
  endtask

  typedef struct {
    int          sel;
    int          lat;
    bit          corrupt;
    logic [26:0] caddr;
    logic [31:0] cdata;
    logic        exp_pass;
    logic [15:0] exp_err;
    logic [26:0] exp_ffa;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] lit_wdata [4] = '{32'hA5A5_0000, 32'hA5A5_0021, 32'hA5A5_0042, 32'hA5A5_0063};
  logic [26:0] lit_waddr [4] = '{27'h7FF_FFFE, 27'h7FF_FFFF, 27'h0, 27'h1};

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int   cnt, exp_err, k;
    logic [26:0] exp_ffa;

    vecs[0] = '{sel:0, lat:3, corrupt:0, caddr:27'h0, cdata:32'h0,
                exp_pass:1'b1, exp_err:16'd0, exp_ffa:27'h0};
    vecs[1] = '{sel:0, lat:3, corrupt:1, caddr:27'h2, cdata:32'h0,
                exp_pass:1'b0, exp_err:16'd1, exp_ffa:27'h2};
    vecs[2] = '{sel:1, lat:1, corrupt:0, caddr:27'h0, cdata:32'h0,
                exp_pass:1'b1, exp_err:16'd0, exp_ffa:27'h0};
    vecs[3] = '{sel:0, lat:0, corrupt:1, caddr:27'h0, cdata:32'hA5A5_0001,
                exp_pass:1'b0, exp_err:16'd1, exp_ffa:27'h0};
    vecs[4] = '{sel:1, lat:2, corrupt:1, caddr:27'h7FF_FFFF, cdata:32'h1,
                exp_pass:1'b0, exp_err:16'd1, exp_ffa:27'h7FF_FFFF};

    sel = 0; rst = 1'b1; start_v = 3'b000; lat_cfg = 0; rand_lat = 0; never_ready = 0;
    pv_valid = 1'b0; pv_fields = '0; stab_bad = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_valid", 64'(q_valid[0]), 64'd0);
    chk("rst_addr",  64'(q_addr[0]),  64'd0);
    chk("rst_data",  64'(q_data[0]),  64'd0);
    chk("rst_rw",    64'(q_rw[0]),    64'd0);
    chk("rst_busy",  64'(q_busy[0]),  64'd0);
    chk("rst_done",  64'(q_done[0]),  64'd0);
    chk("rst_pass",  64'(q_pass[0]),  64'd0);
    chk("rst_err",   64'(q_err[0]),   64'd0);
    chk("rst_ffa",   64'(q_ffa[0]),   64'd0);
    chk("rst_to",    64'(q_to[0]),    64'd0);
    chk("rst_led",   64'(q_led[0]),   64'd0);

    // Table-driven full runs
    for (int v = 0; v < 5; v++) begin
      cval.delete();
      if (vecs[v].corrupt) cval[vecs[v].caddr] = vecs[v].cdata;
      lat_cfg = vecs[v].lat;
      run_scn(vecs[v].sel, 400);
      chk("tbl_pass", 64'(q_pass[vecs[v].sel]), 64'(vecs[v].exp_pass));
      chk("tbl_err",  64'(q_err[vecs[v].sel]),  64'(vecs[v].exp_err));
      chk("tbl_ffa",  64'(q_ffa[vecs[v].sel]),  64'(vecs[v].exp_ffa));
      chk("tbl_led",  64'(q_led[vecs[v].sel]),  64'(vecs[v].exp_pass));
      chk("tbl_busy", 64'(q_busy[vecs[v].sel]), 64'd0);
      chk("tbl_to",   64'(q_to[vecs[v].sel]),   64'd0);
      chk_seq(vecs[v].sel);
      if (log_q.size() >= 4) begin
        for (int i = 0; i < 4; i++) begin
          if (vecs[v].sel == 0) chk("lit_wdata", 64'(log_q[i].data), 64'(lit_wdata[i]));
          if (vecs[v].sel == 1) chk("lit_waddr", 64'(log_q[i].addr), 64'(lit_waddr[i]));
        end
      end
    end

    // Handshake timing: start -> valid next cycle; ready -> gap -> next request
    cval.delete();
    lat_cfg = 0;
    sel = 0;
    prep();
    start_v[0] = 1'b1;
    tick();
    start_v = 3'b000;
    chk("t_start_valid", 64'(q_valid[0]), 64'd1);
    chk("t_start_busy",  64'(q_busy[0]),  64'd1);
    chk("t_first_data",  64'(q_data[0]),  64'hA5A5_0000);
    tick();
    chk("t_ready_seen",  64'(m_ready), 64'd1);
    tick();
    chk("t_gap_valid",   64'(q_valid[0]), 64'd0);
    tick();
    chk("t_next_valid",  64'(q_valid[0]), 64'd1);
    chk("t_next_addr",   64'(q_addr[0]),  64'd1);
    wait_done(0, 400);
    chk("t_pass", 64'(q_pass[0]), 64'd1);

    // start held high for the whole busy period, final ready included
    lat_cfg = 3;
    prep();
    start_v[0] = 1'b1;
    tick();
    k = 0;
    while (!q_done[0] && k < 400) begin
      tick();
      start_v[0] = q_busy[0];
      k++;
    end
    start_v = 3'b000;
    chk("sb_done", 64'(q_done[0]), 64'd1);
    chk("sb_pass", 64'(q_pass[0]), 64'd1);
    chk("sb_err",  64'(q_err[0]),  64'd0);
    chk("sb_led",  64'(q_led[0]),  64'd1);
    chk_seq(0);
    tick();
    chk("sb_stays_done", 64'(q_busy[0]), 64'd0);

    // Reset during the second read
    cval.delete();
    cval[27'h0] = 32'h0;
    prep();
    start_v[0] = 1'b1;
    tick();
    start_v = 3'b000;
    k = 0;
    while (!(log_q.size() == 5 && m_valid && !m_ready) && k < 200) begin
      tick();
      k++;
    end
    chk("mr_second_read", 64'(log_q.size() == 5 && m_valid && !m_rw), 64'd1);
    chk("mr_err_before",  64'(q_err[0]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", 64'(q_valid[0]), 64'd0);
    chk("mr_busy",  64'(q_busy[0]),  64'd0);
    chk("mr_done",  64'(q_done[0]),  64'd0);
    chk("mr_err",   64'(q_err[0]),   64'd0);
    cval.delete();
    run_scn(0, 400);
    chk("mr_fresh_pass", 64'(q_pass[0]), 64'd1);
    chk_seq(0);

    // Memory that never answers
    never_ready = 1;
    prep();
    start_v[0] = 1'b1;
    tick();
    start_v = 3'b000;
`ifdef MEM_BIST_TIMEOUT_EN
    cnt = q_valid[0] ? 1 : 0;
    k = 0;
    while (!q_to[0] && k < 100) begin
      tick();
      if (q_valid[0]) cnt++;
      k++;
    end
    chk("to_valid_cycles", 64'(cnt), 64'd16);
    chk("to_flag",  64'(q_to[0]),    64'd1);
    chk("to_done",  64'(q_done[0]),  64'd1);
    chk("to_pass",  64'(q_pass[0]),  64'd0);
    chk("to_valid", 64'(q_valid[0]), 64'd0);
    chk("to_led",   64'(q_led[0]),   64'd0);
`else
    repeat (60) tick();
    chk("nto_valid", 64'(q_valid[0]), 64'd1);
    chk("nto_busy",  64'(q_busy[0]),  64'd1);
    chk("nto_done",  64'(q_done[0]),  64'd0);
    chk("nto_flag",  64'(q_to[0]),    64'd0);
`endif
    never_ready = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Randomized runs on the 16-word instance with random latency and faults
    rand_lat = 1;
    for (int it = 0; it < 6; it++) begin
      cval.delete();
      exp_err = 0;
      exp_ffa = 27'h0;
      for (int i = 0; i < 16; i++) begin
        logic [26:0] a;
        a = ref_addr(2, i);
        if ($urandom_range(0, 3) == 0) begin
          cval[a] = ref_pat(2, a) ^ 32'($urandom_range(1, 32'hFFFF));
          if (exp_err == 0) exp_ffa = a;
          exp_err++;
        end
      end
      run_scn(2, 2000);
      chk("rnd_pass", 64'(q_pass[2]), 64'(exp_err == 0));
      chk("rnd_err",  64'(q_err[2]),  64'(exp_err));
      chk("rnd_ffa",  64'(q_ffa[2]),  64'(exp_ffa));
      chk("rnd_led",  64'(q_led[2]),  64'(exp_err == 0));
      chk_seq(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
